// File: rtl/ipf_feeder.sv
`default_nettype none
// ============================================================================
// Module   : ipf_feeder
// Brief    : Fetches input rows and kernel weights from word memory and
//            sequences them into the IPF engine's load/compute port.
// Revision : 1.0 - initial release
// ============================================================================
module ipf_feeder #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 16,
    parameter int ROWS     = 8,
    parameter int COMP_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        wsize,
    input  logic [7:0]        num_tiles,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] w_base,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] i_data,
    output logic              i_valid,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    output logic [1:0]        ctrl,
    output logic [1:0]        Wsize,
    input  logic              ipf_finish,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        tile_cnt
);

    localparam logic [1:0]         c_CTRL_END    = 2'd0;
    localparam logic [1:0]         c_CTRL_START  = 2'd1;
    localparam logic [1:0]         c_CTRL_HOLD   = 2'd2;
    localparam int                 c_CNT_W       = 8;
    localparam int                 c_CYC_W       = (COMP_CYC > 1) ? $clog2(COMP_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_ROWS        = c_CNT_W'(ROWS);
    localparam logic [c_CNT_W-1:0] c_NW_SMALL    = c_CNT_W'(9);
    localparam logic [c_CNT_W-1:0] c_NW_LARGE    = c_CNT_W'(25);
    localparam logic [c_CNT_W-1:0] c_MAX_OUTST   = c_CNT_W'(2);
    localparam logic [ADDR_W-1:0]  c_PASS_STRIDE = ADDR_W'(25);
    localparam logic [c_CYC_W-1:0] c_CYC_LAST    = c_CYC_W'(COMP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_I  = 3'd1,
        S_LOAD_W  = 3'd2,
        S_COMPUTE = 3'd3,
        S_HOLDC   = 3'd4,
        S_END     = 3'd5
    } state_t;

    state_t              r_state;
    logic [7:0]          r_ntiles;
    logic [ADDR_W-1:0]   r_ia;
    logic [ADDR_W-1:0]   r_wb;
    logic                r_pass;
    logic [c_CNT_W-1:0]  r_issued;
    logic [c_CNT_W-1:0]  r_ret;
    logic [c_CYC_W-1:0]  r_cyc;

    logic                w_load_i;
    logic                w_load_w;
    logic                w_loading;
    logic                w_stalled;
    logic                w_phase_done;
    logic                w_last_pass;
    logic [c_CNT_W-1:0]  w_total;
    logic [c_CNT_W-1:0]  w_issued_nx;
    logic [c_CNT_W-1:0]  w_ret_nx;
    logic [ADDR_W-1:0]   w_phase_base;
    logic [7:0]          w_tiles_nx;

    assign w_load_i     = (r_state == S_LOAD_I);
    assign w_load_w     = (r_state == S_LOAD_W);
    assign w_loading    = w_load_i || w_load_w;
    assign w_stalled    = mem_rd && !mem_ready;
    assign w_total      = w_load_i ? c_ROWS : ((Wsize == 2'd0) ? c_NW_SMALL : c_NW_LARGE);
    assign w_issued_nx  = r_issued + c_CNT_W'(mem_rd && mem_ready);
    assign w_ret_nx     = r_ret + c_CNT_W'(w_loading && mem_rvalid);
    assign w_phase_done = w_loading && (w_ret_nx == w_total);
    assign w_last_pass  = (Wsize != 2'd2) || r_pass;
    assign w_phase_base = w_load_i ? r_ia : (r_pass ? (r_wb + c_PASS_STRIDE) : r_wb);
    assign w_tiles_nx   = tile_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ntiles <= '0;
            r_ia     <= '0;
            r_wb     <= '0;
            r_pass   <= 1'b0;
            r_issued <= '0;
            r_ret    <= '0;
            r_cyc    <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            i_data   <= '0;
            i_valid  <= 1'b0;
            w_data   <= '0;
            w_valid  <= 1'b0;
            ctrl     <= c_CTRL_HOLD;
            Wsize    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            tile_cnt <= '0;
        end else begin
            i_valid <= 1'b0;
            w_valid <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;

            // Read data is steered by phase; a phase never holds both kinds.
            if (mem_rvalid && w_load_i) begin
                i_data  <= mem_rdata;
                i_valid <= 1'b1;
            end
            if (mem_rvalid && w_load_w) begin
                w_data  <= mem_rdata;
                w_valid <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (wsize == 2'd3) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            Wsize    <= wsize;
                            r_ntiles <= num_tiles;
                            r_ia     <= i_base;
                            r_wb     <= w_base;
                            r_pass   <= 1'b0;
                            tile_cnt <= '0;
                            busy     <= 1'b1;
                            if (num_tiles == 8'd0) begin
                                ctrl    <= c_CTRL_END;
                                r_state <= S_END;
                            end else begin
                                mem_rd   <= 1'b1;
                                mem_addr <= i_base;
                                r_state  <= S_LOAD_I;
                            end
                        end
                    end
                end

                S_LOAD_I, S_LOAD_W: begin
                    if (w_phase_done) begin
                        r_issued <= '0;
                        r_ret    <= '0;
                        if (w_load_i) begin
                            r_ia     <= r_ia + ADDR_W'(ROWS);
                            mem_rd   <= 1'b1;
                            mem_addr <= r_wb;
                            r_state  <= S_LOAD_W;
                        end else begin
                            mem_rd  <= 1'b0;
                            ctrl    <= c_CTRL_START;
                            r_cyc   <= '0;
                            r_state <= S_COMPUTE;
                        end
                    end else begin
                        r_issued <= w_issued_nx;
                        r_ret    <= w_ret_nx;
                        // At most two reads in flight; a stalled request is frozen.
                        if (!w_stalled) begin
                            mem_rd   <= (w_issued_nx < w_total) &&
                                        ((w_issued_nx - w_ret_nx) < c_MAX_OUTST);
                            mem_addr <= w_phase_base + ADDR_W'(w_issued_nx);
                        end
                    end
                end

                S_COMPUTE: begin
                    if (r_cyc == c_CYC_LAST) begin
                        ctrl    <= c_CTRL_HOLD;
                        r_state <= S_HOLDC;
                    end else begin
                        r_cyc <= r_cyc + c_CYC_W'(1);
                    end
                end

                S_HOLDC: begin
                    if (!w_last_pass) begin
                        r_pass   <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= r_wb + c_PASS_STRIDE;
                        r_state  <= S_LOAD_W;
                    end else begin
                        r_pass   <= 1'b0;
                        tile_cnt <= w_tiles_nx;
                        if (w_tiles_nx < r_ntiles) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= r_ia;
                            r_state  <= S_LOAD_I;
                        end else begin
                            ctrl    <= c_CTRL_END;
                            r_state <= S_END;
                        end
                    end
                end

                S_END: begin
                    if (ipf_finish) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        ctrl    <= c_CTRL_HOLD;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ipf_feeder.md
Name: ipf_feeder

Overview:
- Sequencer and transmitter that drives the IPF convolution engine's load/compute port.
- Fetches input rows and kernel weights from a 64-bit word memory and streams them as i_data/i_valid and w_data/w_valid.
- Issues the ctrl protocol to IPF: END=0, START=1, HOLD=2.
- Runs a programmable number of tiles, then ends the IPF and reports done.

Parameters:
- DATA_W, 64, memory and IPF data word width.
- ADDR_W, 16, memory word address width.
- ROWS, 8, input words loaded per tile (IPF rega..regh).
- COMP_CYC, 32, cycles ctrl=START is held per pass (4 weight groups x 8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job start pulse.
- wsize  in  2  kernel size: 0=3x3, 1=5x5, 2=7x7, 3=reserved.
- num_tiles  in  8  tiles to process.
- i_base  in  ADDR_W  first input word address.
- w_base  in  ADDR_W  first weight word address.
- mem_rd  out  1  read request.
- mem_addr  out  ADDR_W  read address.
- mem_ready  in  1  request accepted when mem_rd&&mem_ready.
- mem_rvalid  in  1  read data valid, exactly 1 cycle after acceptance.
- mem_rdata  in  DATA_W  read data.
- i_data  out  DATA_W  input word to IPF.
- i_valid  out  1  input word strobe.
- w_data  out  DATA_W  weight word to IPF.
- w_valid  out  1  weight word strobe.
- ctrl  out  2  IPF control.
- Wsize  out  2  registered copy of wsize, forwarded to IPF.
- ipf_finish  in  1  IPF finish flag.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on reserved wsize.
- tile_cnt  out  8  tiles completed in the current job.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, ctrl=2 (HOLD), all other outputs 0, address and word counters 0.
- Reset mid-job aborts the job immediately; no partial words are emitted after reset release.
- Weight words per pass (NW): 3x3=9, 5x5=25, 7x7=25.
- Passes per tile (NP): 7x7 runs 2 passes; all other sizes run 1 pass.
- IDLE:
  - start with wsize=3: err pulses, done pulses, no memory traffic.
  - start with num_tiles=0: go to END.
  - Otherwise latch all job inputs, busy=1, go to LOAD_I.
  - start while busy is ignored.
- LOAD_I: read ROWS words from ia, ia+1, ...; ia starts at i_base and continues across tiles without reset.
- LOAD_W: read NW words from w_base + pass*25; weight addresses restart every tile.
- Word forwarding: each mem_rvalid word drives i_data/i_valid (LOAD_I) or w_data/w_valid (LOAD_W) for exactly one cycle.
  - i_valid and w_valid are never high together, because IPF prioritises i_valid.
  - A phase ends only when all issued reads have returned. Outstanding reads never exceed 2.
  - While mem_ready=0, mem_rd and mem_addr hold their values.
- Transition rule: the next phase starts the cycle after the last rvalid of the current phase.
- ctrl=2 throughout LOAD_I and LOAD_W.
- COMPUTE: ctrl=1 for exactly COMP_CYC cycles.
- HOLDC: ctrl=2 for 1 cycle, which returns IPF to WAIT and clears its weights.
  - If pass < NP-1: pass++ and go to LOAD_W. The 7x7 second half does not reload inputs.
  - Else: tile_cnt++; go to LOAD_I if tile_cnt < num_tiles, otherwise go to END.
- END: ctrl=0 until ipf_finish=1, then done pulses, busy=0, go to IDLE; ctrl returns to 2.
- ctrl changes only on clock edges. All outputs are registered.
- tile_cnt holds its final value until the next accepted start.

Test Plan:
- 3x3, num_tiles=1, mem_ready=1:
  - 8 i_valid words equal to mem[i_base..+7], then 9 w_valid words, then ctrl=1 for 32 cycles.
  - Then ctrl=2 for 1 cycle, ctrl=0; done pulses 1 cycle after ipf_finish; tile_cnt=1.
- 7x7, num_tiles=1:
  - Weights read from w_base..+24, then COMPUTE/HOLD, then w_base+25..+49 with no second input load.
  - Exactly 50 w_valid pulses and 8 i_valid pulses in total.
- 5x5, num_tiles=3:
  - Input addresses i_base..i_base+23 contiguous; weight addresses w_base..+24 repeated 3 times; tile_cnt=3.
- mem_ready toggled pseudo-randomly:
  - Word order and count are unchanged, mem_addr is stable while stalled, i_valid/w_valid are never coincident.
- Edge jobs:
  - wsize=3: err and done pulse, no mem_rd.
  - num_tiles=0: ctrl=0 immediately, done follows ipf_finish.
  - start while busy: ignored.
- rst=0 asserted mid-LOAD_W:
  - All outputs go to reset values asynchronously, ctrl=2.
  - A new start after release runs a clean job.
